// File: rtl/img_csc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : img_csc_pkg
// Description : Shared definitions for the RGB <-> YCbCr444 colour-space
//               converter: conversion modes, Q8 coefficient tables and
//               error-flag bit indices. Independent of the component width.
// Revision    : 1.0 - initial release
// ============================================================================
package img_csc_pkg;

    // Mode encoding is {dir, std}: bit 1 selects inverse, bit 0 selects BT.709.
    typedef enum logic [1:0] {
        CSC_601_FWD = 2'd0,
        CSC_709_FWD = 2'd1,
        CSC_601_INV = 2'd2,
        CSC_709_INV = 2'd3
    } csc_mode_e;

    // Signed Q8 coefficient width; the largest magnitude is 475.
    localparam int COEF_W = 10;
    typedef logic [COEF_W-1:0] coef_t;

    // Error-flag bit indices.
    localparam int ERR_CLAMP    = 0;
    localparam int ERR_HS_NO_VS = 1;
    localparam int ERR_VS_NO_FS = 2;
    localparam int ERR_CFG_CHG  = 3;
    localparam int ERR_NB       = 4;

    // Row-major 3x3 matrices, one per mode. Row = output channel, column =
    // input component. Inverse modes carry the Y term as a 256 (1.0 in Q8)
    // coefficient so the shared +128/>>8 rounding applies uniformly.
    localparam int CSC_COEF [4][9] = '{
        '{  77,  150,   29,  -43,  -85,  128,  128, -107,  -21 },
        '{  54,  183,   18,  -29,  -99,  128,  128, -116,  -12 },
        '{ 256,    0,  359,  256,  -88, -183,  256,  454,    0 },
        '{ 256,    0,  403,  256,  -48, -120,  256,  475,    0 }
    };

    function automatic csc_mode_e csc_mode(input logic dir, input logic std);
        return csc_mode_e'({dir, std});
    endfunction

    function automatic logic csc_is_inv(input csc_mode_e mode);
        return (mode == CSC_601_INV) || (mode == CSC_709_INV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/img_csc_mac3.sv
`default_nettype none
// ============================================================================
// Module      : img_csc_mac3
// Description : One output channel of the colour-space converter. Three
//               signed products (stage 2), sum with round-half-up and >>8
//               (stage 3), optional mid-scale offset and clamp to the
//               component range (stage 4). Operands arrive already
//               registered (stage 1) from the parent.
// Ports       : i_sys_clk/i_sys_resetn  clock, async active-low reset
//               i_vld      pixel valid, stage-1 aligned
//               i_add_ofs  add 2^(WD-1) at stage 4, stage-1 aligned
//               i_op0..2   two's-complement operands, WD+1 bits
//               i_coef0..2 Q8 coefficients, stage-1 aligned
//               o_dat      clamped result, holds while no valid pixel
//               o_sat      high in the cycle a clamped value is loaded
// Revision    : 1.0 - initial release
// ============================================================================
module img_csc_mac3
    import img_csc_pkg::*;
#(
    parameter int WD_IMG_DATA = 8
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_resetn,
    input  logic                   i_vld,
    input  logic                   i_add_ofs,
    input  logic [WD_IMG_DATA:0]   i_op0,
    input  logic [WD_IMG_DATA:0]   i_op1,
    input  logic [WD_IMG_DATA:0]   i_op2,
    input  coef_t                  i_coef0,
    input  coef_t                  i_coef1,
    input  coef_t                  i_coef2,
    output logic [WD_IMG_DATA-1:0] o_dat,
    output logic                   o_sat
);

    localparam int WD = WD_IMG_DATA;
    localparam int PW = WD + 11;   // product width
    localparam int SW = WD + 13;   // sum width
    localparam int RW = SW - 8;    // after >>8
    localparam int VW = RW + 1;    // after offset add

    localparam logic [SW-1:0] c_rnd  = SW'(128);
    localparam logic [VW-1:0] c_half = VW'(2 ** (WD - 1));

    // All arithmetic is two's complement on plain vectors; signs are
    // propagated by explicit extension so every operation is width-exact.
    logic [PW-1:0] w_op_x0, w_op_x1, w_op_x2;
    logic [PW-1:0] w_cf_x0, w_cf_x1, w_cf_x2;
    logic [PW-1:0] prod0_d, prod1_d, prod2_d;
    logic [PW-1:0] prod0_q, prod1_q, prod2_q;
    logic          vld_s2_d, vld_s2_q, ofs_s2_d, ofs_s2_q;
    logic [SW-1:0] w_sum;
    logic [RW-1:0] rnd_d, rnd_q;
    logic          vld_s3_d, vld_s3_q, ofs_s3_d, ofs_s3_q;
    logic [VW-1:0] w_val;
    logic          w_neg, w_over;
    logic [WD-1:0] w_clamp;
    logic [WD-1:0] dat_d, dat_q;

    // Stage 2: products.
    always_comb begin
        w_op_x0  = {{(PW-WD-1){i_op0[WD]}}, i_op0};
        w_op_x1  = {{(PW-WD-1){i_op1[WD]}}, i_op1};
        w_op_x2  = {{(PW-WD-1){i_op2[WD]}}, i_op2};
        w_cf_x0  = {{(PW-COEF_W){i_coef0[COEF_W-1]}}, i_coef0};
        w_cf_x1  = {{(PW-COEF_W){i_coef1[COEF_W-1]}}, i_coef1};
        w_cf_x2  = {{(PW-COEF_W){i_coef2[COEF_W-1]}}, i_coef2};
        prod0_d  = w_op_x0 * w_cf_x0;
        prod1_d  = w_op_x1 * w_cf_x1;
        prod2_d  = w_op_x2 * w_cf_x2;
        vld_s2_d = i_vld;
        ofs_s2_d = i_add_ofs;
    end

    // Stage 3: sum, round half up, arithmetic >>8 (taking the upper bits of
    // a sign-extended sum is exactly an arithmetic shift).
    always_comb begin
        w_sum    = {{2{prod0_q[PW-1]}}, prod0_q}
                 + {{2{prod1_q[PW-1]}}, prod1_q}
                 + {{2{prod2_q[PW-1]}}, prod2_q}
                 + c_rnd;
        rnd_d    = w_sum[SW-1:8];
        vld_s3_d = vld_s2_q;
        ofs_s3_d = ofs_s2_q;
    end

    // Stage 4: offset and clamp; the output register only loads on a valid
    // pixel so the last result is held between pixels.
    always_comb begin
        w_val   = {rnd_q[RW-1], rnd_q} + (ofs_s3_q ? c_half : '0);
        w_neg   = w_val[VW-1];
        w_over  = ~w_neg & (|w_val[VW-2:WD]);
        if (w_neg) begin
            w_clamp = '0;
        end else if (w_over) begin
            w_clamp = {WD{1'b1}};
        end else begin
            w_clamp = w_val[WD-1:0];
        end
        dat_d = vld_s3_q ? w_clamp : dat_q;
        o_sat = vld_s3_q & (w_neg | w_over);
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            prod0_q  <= '0;
            prod1_q  <= '0;
            prod2_q  <= '0;
            vld_s2_q <= 1'b0;
            ofs_s2_q <= 1'b0;
            rnd_q    <= '0;
            vld_s3_q <= 1'b0;
            ofs_s3_q <= 1'b0;
            dat_q    <= '0;
        end else begin
            prod0_q  <= prod0_d;
            prod1_q  <= prod1_d;
            prod2_q  <= prod2_d;
            vld_s2_q <= vld_s2_d;
            ofs_s2_q <= ofs_s2_d;
            rnd_q    <= rnd_d;
            vld_s3_q <= vld_s3_d;
            ofs_s3_q <= ofs_s3_d;
            dat_q    <= dat_d;
        end
    end

    assign o_dat = dat_q;

endmodule
`default_nettype wire

// File: rtl/img_csc_rgb_ycbcr444.sv
`default_nettype none
// ============================================================================
// Module      : img_csc_rgb_ycbcr444
// Description : Pipelined RGB <-> YCbCr444 colour-space converter, BT.601 /
//               BT.709 full range, configuration latched per frame. Four
//               stage pipeline, one pixel per clock, syncs delay-matched,
//               sticky per-frame error flags.
// Ports       : i_sys_clk, i_sys_resetn   clock, async active-low reset
//               i_cfg_dir  0 = RGB->YCbCr, 1 = YCbCr->RGB
//               i_cfg_std  0 = BT.601, 1 = BT.709
//               s_img_c_fsync/vsync/hsync  input frame/line/pixel flags
//               s_img_mdat0..2             input components
//               m_img_c_fsync/vsync/hsync  flags delayed by NB_PIPE
//               m_img_mdat0..2             converted components
//               m_err_csc_info1            sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module img_csc_rgb_ycbcr444
    import img_csc_pkg::*;
#(
    parameter int MD_SIM_ABLE = 0,
    parameter int WD_IMG_DATA = 8,
    parameter int WD_ERR_INFO = 4,
    parameter int NB_PIPE     = 4
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_resetn,
    input  logic                   i_cfg_dir,
    input  logic                   i_cfg_std,
    input  logic                   s_img_c_fsync,
    input  logic                   s_img_c_vsync,
    input  logic                   s_img_c_hsync,
    input  logic [WD_IMG_DATA-1:0] s_img_mdat0,
    input  logic [WD_IMG_DATA-1:0] s_img_mdat1,
    input  logic [WD_IMG_DATA-1:0] s_img_mdat2,
    output logic                   m_img_c_fsync,
    output logic                   m_img_c_vsync,
    output logic                   m_img_c_hsync,
    output logic [WD_IMG_DATA-1:0] m_img_mdat0,
    output logic [WD_IMG_DATA-1:0] m_img_mdat1,
    output logic [WD_IMG_DATA-1:0] m_img_mdat2,
    output logic [WD_ERR_INFO-1:0] m_err_csc_info1
);

    localparam int WD = WD_IMG_DATA;
    localparam logic [WD:0] c_half = (WD+1)'(2 ** (WD - 1));

    // Elaboration-time parameter checks.
    if (NB_PIPE != 4) begin : g_chk_pipe
        $error("img_csc_rgb_ycbcr444: NB_PIPE must be 4");
    end
    if ((WD_IMG_DATA < 8) || (WD_IMG_DATA > 12)) begin : g_chk_wd
        $error("img_csc_rgb_ycbcr444: WD_IMG_DATA must be 8..12");
    end
    if (WD_ERR_INFO < ERR_NB) begin : g_chk_err
        $error("img_csc_rgb_ycbcr444: WD_ERR_INFO must be >= 4");
    end
    if ((MD_SIM_ABLE != 0) && (MD_SIM_ABLE != 1)) begin : g_chk_sim
        $error("img_csc_rgb_ycbcr444: MD_SIM_ABLE must be 0 or 1");
    end

    logic              fsync_prev_d, fsync_prev_q;
    logic              w_fsync_rise;
    csc_mode_e         w_cfg_in;
    csc_mode_e         w_mode_cur;
    csc_mode_e         cfg_mode_d, cfg_mode_q;
    csc_mode_e         mode_s1_d, mode_s1_q;
    logic              w_inv;
    logic [WD:0]       op0_d, op1_d, op2_d;
    logic [WD:0]       op0_q, op1_q, op2_q;
    logic [NB_PIPE-1:0] fs_sr_d, fs_sr_q;
    logic [NB_PIPE-1:0] vs_sr_d, vs_sr_q;
    logic [NB_PIPE-1:0] hs_sr_d, hs_sr_q;
    logic [ERR_NB-1:0] w_evt;
    logic [ERR_NB-1:0] err_d, err_q;
    logic [WD-1:0]     w_dat [3];
    logic [2:0]        w_sat;

    // Config latch and stage 1. A pixel arriving in the same cycle as the
    // fsync rise already uses the newly latched mode, so the mode used by
    // the datapath bypasses the latch on that cycle and travels with the
    // pixel from stage 1 onwards.
    always_comb begin
        w_fsync_rise = s_img_c_fsync & ~fsync_prev_q;
        fsync_prev_d = s_img_c_fsync;
        w_cfg_in     = csc_mode(i_cfg_dir, i_cfg_std);
        w_mode_cur   = w_fsync_rise ? w_cfg_in : cfg_mode_q;
        cfg_mode_d   = w_mode_cur;
        mode_s1_d    = w_mode_cur;
        w_inv        = csc_is_inv(w_mode_cur);

        // Chroma is re-centred around zero for the inverse transform.
        op0_d = {1'b0, s_img_mdat0};
        op1_d = w_inv ? ({1'b0, s_img_mdat1} - c_half) : {1'b0, s_img_mdat1};
        op2_d = w_inv ? ({1'b0, s_img_mdat2} - c_half) : {1'b0, s_img_mdat2};

        fs_sr_d = {fs_sr_q[NB_PIPE-2:0], s_img_c_fsync};
        vs_sr_d = {vs_sr_q[NB_PIPE-2:0], s_img_c_vsync};
        hs_sr_d = {hs_sr_q[NB_PIPE-2:0], s_img_c_hsync};
    end

    // Error flags. The clear on an fsync rise replaces the old flags with
    // this cycle's events, so an event coinciding with the clear is kept.
    always_comb begin
        w_evt               = '0;
        w_evt[ERR_CLAMP]    = |w_sat;
        w_evt[ERR_HS_NO_VS] = s_img_c_hsync & ~s_img_c_vsync;
        w_evt[ERR_VS_NO_FS] = s_img_c_vsync & ~s_img_c_fsync;
        w_evt[ERR_CFG_CHG]  = s_img_c_fsync & fsync_prev_q & (w_cfg_in != cfg_mode_q);
        err_d               = w_fsync_rise ? w_evt : (err_q | w_evt);
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            fsync_prev_q <= 1'b0;
            cfg_mode_q   <= CSC_601_FWD;
            mode_s1_q    <= CSC_601_FWD;
            op0_q        <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            fs_sr_q      <= '0;
            vs_sr_q      <= '0;
            hs_sr_q      <= '0;
            err_q        <= '0;
        end else begin
            fsync_prev_q <= fsync_prev_d;
            cfg_mode_q   <= cfg_mode_d;
            mode_s1_q    <= mode_s1_d;
            op0_q        <= op0_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            fs_sr_q      <= fs_sr_d;
            vs_sr_q      <= vs_sr_d;
            hs_sr_q      <= hs_sr_d;
            err_q        <= err_d;
        end
    end

    // Stages 2..4, one instance per output channel. Channels 1 and 2 are
    // chroma in forward mode and get the mid-scale offset.
    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic w_ofs;
        assign w_ofs = (ch == 0) ? 1'b0 : ~csc_is_inv(mode_s1_q);

        img_csc_mac3 #(
            .WD_IMG_DATA (WD)
        ) u_mac3 (
            .i_sys_clk    (i_sys_clk),
            .i_sys_resetn (i_sys_resetn),
            .i_vld        (hs_sr_q[0]),
            .i_add_ofs    (w_ofs),
            .i_op0        (op0_q),
            .i_op1        (op1_q),
            .i_op2        (op2_q),
            .i_coef0      (coef_t'(CSC_COEF[mode_s1_q][ch*3 + 0])),
            .i_coef1      (coef_t'(CSC_COEF[mode_s1_q][ch*3 + 1])),
            .i_coef2      (coef_t'(CSC_COEF[mode_s1_q][ch*3 + 2])),
            .o_dat        (w_dat[ch]),
            .o_sat        (w_sat[ch])
        );
    end

    assign m_img_c_fsync   = fs_sr_q[NB_PIPE-1];
    assign m_img_c_vsync   = vs_sr_q[NB_PIPE-1];
    assign m_img_c_hsync   = hs_sr_q[NB_PIPE-1];
    assign m_img_mdat0     = w_dat[0];
    assign m_img_mdat1     = w_dat[1];
    assign m_img_mdat2     = w_dat[2];
    assign m_err_csc_info1 = WD_ERR_INFO'(err_q);

endmodule
`default_nettype wire

// File: tb/tb_img_csc_rgb_ycbcr444.sv
`default_nettype none
// ============================================================================
// Module      : tb_img_csc_rgb_ycbcr444
// Description : Directed self-checking bench for img_csc_rgb_ycbcr444 with
//               8-bit components and hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_img_csc_rgb_ycbcr444;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_dir, cfg_std;
    logic       s_fs, s_vs, s_hs;
    logic [7:0] s_d0, s_d1, s_d2;
    logic       m_fs, m_vs, m_hs;
    logic [7:0] m_d0, m_d1, m_d2;
    logic [3:0] m_err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    img_csc_rgb_ycbcr444 #(
        .MD_SIM_ABLE (0),
        .WD_IMG_DATA (8),
        .WD_ERR_INFO (4),
        .NB_PIPE     (4)
    ) dut (
        .i_sys_clk       (clk),
        .i_sys_resetn    (rst_n),
        .i_cfg_dir       (cfg_dir),
        .i_cfg_std       (cfg_std),
        .s_img_c_fsync   (s_fs),
        .s_img_c_vsync   (s_vs),
        .s_img_c_hsync   (s_hs),
        .s_img_mdat0     (s_d0),
        .s_img_mdat1     (s_d1),
        .s_img_mdat2     (s_d2),
        .m_img_c_fsync   (m_fs),
        .m_img_c_vsync   (m_vs),
        .m_img_c_hsync   (m_hs),
        .m_img_mdat0     (m_d0),
        .m_img_mdat1     (m_d1),
        .m_img_mdat2     (m_d2),
        .m_err_csc_info1 (m_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Raise fsync/vsync with the given config; flags must read clear after
    // the rising edge has been sampled.
    task automatic frame_start(input logic dir, input logic std);
        @(posedge clk); #1;
        cfg_dir = dir;
        cfg_std = std;
        s_fs    = 1'b1;
        s_vs    = 1'b1;
        @(posedge clk); #1;
        chk("frame.clr", m_err, 0);
    endtask

    task automatic frame_end();
        @(posedge clk); #1;
        s_fs = 1'b0;
        s_vs = 1'b0;
        @(posedge clk); #1;
    endtask

    // One pixel; the result must appear exactly 4 clocks after the input.
    task automatic send_px(input string tag,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                           input logic [3:0] eerr);
        @(posedge clk); #1;
        s_hs = 1'b1;
        s_d0 = a;
        s_d1 = b;
        s_d2 = c;
        @(posedge clk); #1;
        s_hs = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, ".early"}, m_hs, 0);
        @(posedge clk); #1;
        chk({tag, ".hs"},  m_hs, 1);
        chk({tag, ".c0"},  m_d0, e0);
        chk({tag, ".c1"},  m_d1, e1);
        chk({tag, ".c2"},  m_d2, e2);
        chk({tag, ".err"}, m_err, eerr);
    endtask

    initial begin
        rst_n = 1'b0; cfg_dir = 1'b0; cfg_std = 1'b0;
        s_fs = 1'b0; s_vs = 1'b0; s_hs = 1'b0;
        s_d0 = '0; s_d1 = '0; s_d2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.hs",  m_hs, 0);
        chk("rst.fs",  m_fs, 0);
        chk("rst.d0",  m_d0, 0);
        chk("rst.err", m_err, 0);
        rst_n = 1'b1;

        // BT.601 forward
        frame_start(1'b0, 1'b0);
        send_px("f601.black", 8'd0,   8'd0,   8'd0,   8'd0,   8'd128, 8'd128, 4'h0);
        chk("f601.fs", m_fs, 1);
        @(posedge clk); #1;
        chk("f601.hold.hs", m_hs, 0);
        chk("f601.hold.c1", m_d1, 128);
        // Y=(38250+128)>>8=149, Cb=floor(-21547/256)+128=43, Cr=floor(-27157/256)+128=21
        send_px("f601.green", 8'd0,   8'd255, 8'd0,   8'd149, 8'd43,  8'd21,  4'h0);
        send_px("f601.white", 8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128, 4'h0);
        // Cr = 128 + 128 = 256 clamps to 255
        send_px("f601.red",   8'd255, 8'd0,   8'd0,   8'd77,  8'd85,  8'd255, 4'h1);
        send_px("f601.stick", 8'd0,   8'd0,   8'd0,   8'd0,   8'd128, 8'd128, 4'h1);
        frame_end();

        // BT.601 inverse: Cr'=127; R=(65280+45593+128)>>8=433->255,
        // G=(65280-23241+128)>>8=164, B=(65280+128)>>8=255
        frame_start(1'b1, 1'b0);
        send_px("i601", 8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255, 4'h1);
        frame_end();

        // Mid-frame standard change is ignored and flagged
        frame_start(1'b0, 1'b0);
        send_px("cfg.pre",  8'd0, 8'd255, 8'd0, 8'd149, 8'd43, 8'd21, 4'h0);
        cfg_std = 1'b1;
        @(posedge clk); #1;
        chk("cfg.flag", m_err, 4'h8);
        send_px("cfg.keep", 8'd0, 8'd255, 8'd0, 8'd149, 8'd43, 8'd21, 4'h8);
        frame_end();
        // BT.709 forward: Y=(46665+128)>>8=182, Cb=-99+128=29, Cr=-116+128=12
        frame_start(1'b0, 1'b1);
        send_px("f709", 8'd0, 8'd255, 8'd0, 8'd182, 8'd29, 8'd12, 4'h0);

        // fsync falls and rises on consecutive cycles; an hsync-without-vsync
        // event in the rise cycle survives the clear. The pixel uses the
        // config latched by that rise (BT.601).
        @(posedge clk); #1;
        s_fs = 1'b0; s_vs = 1'b0; cfg_dir = 1'b0; cfg_std = 1'b0;
        @(posedge clk); #1;
        s_fs = 1'b1; s_hs = 1'b1; s_d0 = 8'd0; s_d1 = 8'd255; s_d2 = 8'd0;
        @(posedge clk); #1;
        s_hs = 1'b0; s_vs = 1'b1;
        chk("b2b.err", m_err, 4'h2);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b.hs", m_hs, 1);
        chk("b2b.c0", m_d0, 149);
        chk("b2b.c2", m_d2, 21);
        chk("b2b.err2", m_err, 4'h2);
        // vsync high while fsync low
        @(posedge clk); #1;
        s_fs = 1'b0;
        @(posedge clk); #1;
        s_vs = 1'b0;
        chk("vs_no_fs", m_err, 4'h6);

        // BT.709 inverse: Cb'=72, Cr'=-78; R=-23->0, G=123, B=234
        frame_start(1'b1, 1'b1);
        send_px("i709", 8'd100, 8'd200, 8'd50, 8'd0, 8'd123, 8'd234, 4'h1);

        // Asynchronous reset in the middle of a line
        @(posedge clk); #1;
        s_hs = 1'b1; s_d0 = 8'd128; s_d1 = 8'd128; s_d2 = 8'd128;
        repeat (5) @(posedge clk);
        #3;
        chk("arst.pre.hs", m_hs, 1);
        chk("arst.pre.c1", m_d1, 128);
        rst_n = 1'b0;
        #1;
        chk("arst.hs",  m_hs, 0);
        chk("arst.fs",  m_fs, 0);
        chk("arst.c1",  m_d1, 0);
        chk("arst.err", m_err, 0);
        s_hs = 1'b0; s_fs = 1'b0; s_vs = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        frame_start(1'b0, 1'b1);
        send_px("post", 8'd0, 8'd255, 8'd0, 8'd182, 8'd29, 8'd12, 4'h0);
        frame_end();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
